// File: rtl/dsi_rx_packet_parser_pkg.sv
// Shared DSI receive definitions: sync byte, parser state encodings,
// long-packet data-type lookup, header ECC and CRC-16 byte step.
package dsi_rx_packet_parser_pkg;

  localparam logic [7:0]  DSI_SYNC_BYTE     = 8'hB8;
  localparam logic [15:0] DSI_CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] DSI_CRC_POLY_REFL = 16'h8408;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_HUNT    = 4'd1;
  localparam logic [3:0] ST_HDR0    = 4'd2;
  localparam logic [3:0] ST_HDR1    = 4'd3;
  localparam logic [3:0] ST_HDR2    = 4'd4;
  localparam logic [3:0] ST_HDR3    = 4'd5;
  localparam logic [3:0] ST_PAYLOAD = 4'd6;
  localparam logic [3:0] ST_CRC0    = 4'd7;
  localparam logic [3:0] ST_CRC1    = 4'd8;

  typedef struct packed {
    logic [7:0]  di;
    logic [15:0] wc;
  } dsi_hdr_t;

  function automatic logic dsi_is_long_dt(input logic [5:0] dt);
    logic is_long;
    case (dt)
      6'h09, 6'h19, 6'h29, 6'h39,
      6'h0C, 6'h1C, 6'h2C, 6'h3C,
      6'h0D, 6'h0E, 6'h1E, 6'h2E, 6'h3E: is_long = 1'b1;
      default:                           is_long = 1'b0;
    endcase
    return is_long;
  endfunction

  // Hamming parity over {WC hi, WC lo, DI}; same equations as the transmit side.
  function automatic logic [5:0] dsi_ecc24(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13]
         ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14]
         ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15]
         ^ d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15]
         ^ d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18]
         ^ d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17]
         ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

  function automatic logic [15:0] dsi_crc16_byte(input logic [15:0] crc,
                                                 input logic [7:0]  data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ DSI_CRC_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/dsi_rx_packet_parser_crc16.sv
// Byte-wide DSI payload CRC-16 (reflected 0x1021, LSB first); init wins over enable.
module dsi_rx_crc16
  import dsi_rx_packet_parser_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = DSI_CRC_INIT;
    end else if (en_i) begin
      crc_d = dsi_crc16_byte(crc_q, data_i);
    end else begin
      crc_d = crc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= DSI_CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/dsi_rx_packet_parser.sv
// DSI HS lane packet parser: hunts the SoT leader, splits bursts into packets,
// emits header fields and payload bytes, and checks header ECC and payload CRC.
module dsi_rx_packet_parser
  import dsi_rx_packet_parser_pkg::*;
#(
  parameter logic [7:0]  g_sync_byte      = DSI_SYNC_BYTE,
  parameter bit          g_check_zero_crc = 1'b0,
  parameter logic [15:0] g_max_wcount     = 16'd4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hs_active_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        hdr_valid_o,
  output logic [1:0]  hdr_vc_o,
  output logic [5:0]  hdr_dt_o,
  output logic [15:0] hdr_wc_o,
  output logic        hdr_long_o,
  output logic [7:0]  pl_data_o,
  output logic        pl_valid_o,
  output logic        pl_last_o,
  output logic        pkt_done_o,
  output logic        ecc_err_o,
  output logic        crc_err_o,
  output logic        len_err_o,
  output logic        trunc_err_o
);

  logic [3:0]  state_q, state_d;
  dsi_hdr_t    hdr_q, hdr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  crc_lo_q, crc_lo_d;

  logic        hdr_valid_q, hdr_valid_d;
  logic [1:0]  hdr_vc_q, hdr_vc_d;
  logic [5:0]  hdr_dt_q, hdr_dt_d;
  logic [15:0] hdr_wc_q, hdr_wc_d;
  logic        hdr_long_q, hdr_long_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pl_valid_q, pl_valid_d;
  logic        pl_last_q, pl_last_d;
  logic        pkt_done_q, pkt_done_d;
  logic        ecc_err_q, ecc_err_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic        trunc_err_q, trunc_err_d;

  logic        is_long_s;
  logic        ecc_bad_s;
  logic        len_bad_s;
  logic        crc_bad_s;
  logic [15:0] crc_rx_s;
  logic [15:0] crc_calc_s;
  logic        crc_init_s;
  logic        crc_en_s;

  assign is_long_s = dsi_is_long_dt(hdr_q.di[5:0]);
  assign ecc_bad_s = (byte_i != {2'b00, dsi_ecc24({hdr_q.wc, hdr_q.di})});
  assign len_bad_s = is_long_s && (hdr_q.wc > g_max_wcount);
  assign crc_rx_s  = {byte_i, crc_lo_q};
  // A zero checksum means "not computed" unless zero checking is enabled.
  assign crc_bad_s = (crc_rx_s != crc_calc_s) &&
                     !((crc_rx_s == 16'h0000) && !g_check_zero_crc);

  assign crc_en_s   = (state_q == ST_PAYLOAD) && hs_active_i && byte_valid_i;
  assign crc_init_s = (state_q != ST_PAYLOAD) && (state_q != ST_CRC0) &&
                      (state_q != ST_CRC1);

  dsi_rx_crc16 u_crc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .init_i (crc_init_s),
    .en_i   (crc_en_s),
    .data_i (byte_i),
    .crc_o  (crc_calc_s)
  );

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    cnt_d       = cnt_q;
    crc_lo_d    = crc_lo_q;
    hdr_valid_d = 1'b0;
    hdr_vc_d    = hdr_vc_q;
    hdr_dt_d    = hdr_dt_q;
    hdr_wc_d    = hdr_wc_q;
    hdr_long_d  = hdr_long_q;
    pl_data_d   = pl_data_q;
    pl_valid_d  = 1'b0;
    pl_last_d   = 1'b0;
    pkt_done_d  = 1'b0;
    ecc_err_d   = 1'b0;
    crc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    trunc_err_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (hs_active_i) begin
        state_d = ST_HUNT;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (!hs_active_i) begin
      // Burst end: only a packet already in progress counts as truncated.
      state_d = ST_IDLE;
      if ((state_q == ST_HUNT) || (state_q == ST_HDR0)) begin
        trunc_err_d = 1'b0;
      end else begin
        trunc_err_d = 1'b1;
      end
    end else if (byte_valid_i) begin
      case (state_q)
        ST_HUNT: begin
          if (byte_i == g_sync_byte) begin
            state_d = ST_HDR0;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_HDR0: begin
          hdr_d.di = byte_i;
          state_d  = ST_HDR1;
        end
        ST_HDR1: begin
          hdr_d.wc[7:0] = byte_i;
          state_d       = ST_HDR2;
        end
        ST_HDR2: begin
          hdr_d.wc[15:8] = byte_i;
          state_d        = ST_HDR3;
        end
        ST_HDR3: begin
          hdr_valid_d = 1'b1;
          hdr_vc_d    = hdr_q.di[7:6];
          hdr_dt_d    = hdr_q.di[5:0];
          hdr_wc_d    = hdr_q.wc;
          hdr_long_d  = is_long_s;
          ecc_err_d   = ecc_bad_s;
          len_err_d   = len_bad_s;
          cnt_d       = hdr_q.wc;
          if (!is_long_s) begin
            pkt_done_d = 1'b1;
            state_d    = ST_HDR0;
          end else if (ecc_bad_s || len_bad_s) begin
            state_d = ST_HUNT;
          end else if (hdr_q.wc == 16'd0) begin
            state_d = ST_CRC0;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pl_valid_d = 1'b1;
          pl_data_d  = byte_i;
          if (cnt_q <= 16'd1) begin
            pl_last_d = 1'b1;
            cnt_d     = 16'd0;
            state_d   = ST_CRC0;
          end else begin
            cnt_d   = cnt_q - 16'd1;
            state_d = ST_PAYLOAD;
          end
        end
        ST_CRC0: begin
          crc_lo_d = byte_i;
          state_d  = ST_CRC1;
        end
        ST_CRC1: begin
          pkt_done_d = 1'b1;
          crc_err_d  = crc_bad_s;
          state_d    = ST_HDR0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      hdr_q    <= '0;
      cnt_q    <= 16'd0;
      crc_lo_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      cnt_q    <= cnt_d;
      crc_lo_q <= crc_lo_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_valid_q <= 1'b0;
      hdr_vc_q    <= 2'd0;
      hdr_dt_q    <= 6'd0;
      hdr_wc_q    <= 16'd0;
      hdr_long_q  <= 1'b0;
      pl_data_q   <= 8'd0;
      pl_valid_q  <= 1'b0;
      pl_last_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      ecc_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      hdr_valid_q <= hdr_valid_d;
      hdr_vc_q    <= hdr_vc_d;
      hdr_dt_q    <= hdr_dt_d;
      hdr_wc_q    <= hdr_wc_d;
      hdr_long_q  <= hdr_long_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      pl_last_q   <= pl_last_d;
      pkt_done_q  <= pkt_done_d;
      ecc_err_q   <= ecc_err_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign hdr_valid_o = hdr_valid_q;
  assign hdr_vc_o    = hdr_vc_q;
  assign hdr_dt_o    = hdr_dt_q;
  assign hdr_wc_o    = hdr_wc_q;
  assign hdr_long_o  = hdr_long_q;
  assign pl_data_o   = pl_data_q;
  assign pl_valid_o  = pl_valid_q;
  assign pl_last_o   = pl_last_q;
  assign pkt_done_o  = pkt_done_q;
  assign ecc_err_o   = ecc_err_q;
  assign crc_err_o   = crc_err_q;
  assign len_err_o   = len_err_q;
  assign trunc_err_o = trunc_err_q;

endmodule

// File: tb/tb_dsi_rx_packet_parser.sv
// Directed bench for dsi_rx_packet_parser; ECC bytes and the CRC of 2C 00 FF
// (16'h90D3) are hand-computed constants.
module tb_dsi_rx_packet_parser;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        hs_active_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        hdr_valid_o;
  logic [1:0]  hdr_vc_o;
  logic [5:0]  hdr_dt_o;
  logic [15:0] hdr_wc_o;
  logic        hdr_long_o;
  logic [7:0]  pl_data_o;
  logic        pl_valid_o;
  logic        pl_last_o;
  logic        pkt_done_o;
  logic        ecc_err_o;
  logic        crc_err_o;
  logic        len_err_o;
  logic        trunc_err_o;

  int checks = 0;
  int errors = 0;
  int n_hdr = 0, n_done = 0, n_plv = 0, n_last = 0, n_trunc = 0;
  int b_hdr, b_done, b_plv, b_last, b_trunc;

  always #5 clk_i = ~clk_i;

  dsi_rx_packet_parser u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .hs_active_i  (hs_active_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .hdr_valid_o  (hdr_valid_o),
    .hdr_vc_o     (hdr_vc_o),
    .hdr_dt_o     (hdr_dt_o),
    .hdr_wc_o     (hdr_wc_o),
    .hdr_long_o   (hdr_long_o),
    .pl_data_o    (pl_data_o),
    .pl_valid_o   (pl_valid_o),
    .pl_last_o    (pl_last_o),
    .pkt_done_o   (pkt_done_o),
    .ecc_err_o    (ecc_err_o),
    .crc_err_o    (crc_err_o),
    .len_err_o    (len_err_o),
    .trunc_err_o  (trunc_err_o)
  );

  // Count high cycles of each strobe; a stretched pulse shows up as an extra count.
  always @(negedge clk_i) begin
    if (hdr_valid_o) n_hdr <= n_hdr + 1;
    if (pkt_done_o)  n_done <= n_done + 1;
    if (pl_valid_o)  n_plv <= n_plv + 1;
    if (pl_last_o)   n_last <= n_last + 1;
    if (trunc_err_o) n_trunc <= n_trunc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_i       = b;
    byte_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    idle($urandom_range(1, 3));
    send(b);
  endtask

  task automatic snap();
    b_hdr = n_hdr; b_done = n_done; b_plv = n_plv; b_last = n_last; b_trunc = n_trunc;
  endtask

  initial begin
    rst_i = 1'b1; hs_active_i = 1'b0; byte_i = 8'h00; byte_valid_i = 1'b0;
    idle(3);
    chk("rst_hdr", {hdr_vc_o, hdr_dt_o, hdr_wc_o}, 32'd0);
    chk("rst_flags", {hdr_valid_o, hdr_long_o, pl_valid_o, pl_last_o, pkt_done_o,
                      ecc_err_o, crc_err_o, len_err_o, trunc_err_o, pl_data_o}, 32'd0);
    rst_i = 1'b0;
    idle(1);

    // Short packet, preceded by a noise byte before the leader
    hs_active_i = 1'b1; idle(1);
    send(8'h55); send(8'hB8); send(8'h05); send(8'h11); send(8'h00);
    chk("short_early", hdr_valid_o, 32'd0);
    send(8'h36);
    chk("short_fields", {hdr_valid_o, hdr_vc_o, hdr_dt_o, hdr_wc_o}, {1'b1, 2'd0, 6'h05, 16'h0011});
    chk("short_flags", {hdr_long_o, ecc_err_o, len_err_o, pkt_done_o, crc_err_o}, 32'b00010);
    idle(1);
    chk("short_width", {hdr_valid_o, pkt_done_o}, 32'd0);
    hs_active_i = 1'b0; idle(1);
    chk("short_end_silent", trunc_err_o, 32'd0);

    // Corrupted ECC, then a leader-less packet in the same burst
    hs_active_i = 1'b1; idle(1);
    send(8'hB8); send(8'h05); send(8'h11); send(8'h00); send(8'h37);
    chk("bad_ecc", {hdr_valid_o, ecc_err_o, pkt_done_o, crc_err_o}, 32'b1110);
    send(8'h05); send(8'h29); send(8'h00); send(8'h1C);
    chk("b2b_flags", {hdr_valid_o, ecc_err_o, pkt_done_o}, 32'b101);
    chk("b2b_fields", {hdr_vc_o, hdr_dt_o, hdr_wc_o}, {2'd0, 6'h05, 16'h0029});
    hs_active_i = 1'b0; idle(2);

    // Long packet: good CRC, flipped payload bit, zero checksum
    snap();
    hs_active_i = 1'b1; idle(1);
    send(8'hB8); send(8'h39); send(8'h03); send(8'h00); send(8'h09);
    chk("long_hdr", {hdr_valid_o, hdr_long_o, ecc_err_o, len_err_o, pkt_done_o}, 32'b11000);
    chk("long_fields", {hdr_vc_o, hdr_dt_o, hdr_wc_o}, {2'd0, 6'h39, 16'h0003});
    send(8'h2C);
    chk("pl0", {pl_valid_o, pl_last_o, pl_data_o}, {1'b1, 1'b0, 8'h2C});
    send(8'h00);
    chk("pl1", {pl_valid_o, pl_last_o, pl_data_o}, {1'b1, 1'b0, 8'h00});
    send(8'hFF);
    chk("pl2_last", {pl_valid_o, pl_last_o, pl_data_o}, {1'b1, 1'b1, 8'hFF});
    send(8'hD3);
    chk("crc0_quiet", {pl_valid_o, pl_last_o, pkt_done_o}, 32'd0);
    send(8'h90);
    chk("crc_good", {pkt_done_o, crc_err_o}, 32'b10);
    send(8'h39); send(8'h03); send(8'h00); send(8'h09);
    send(8'h2C); send(8'h01); send(8'hFF); send(8'hD3); send(8'h90);
    chk("crc_flip", {pkt_done_o, crc_err_o}, 32'b11);
    send(8'h39); send(8'h03); send(8'h00); send(8'h09);
    send(8'h2C); send(8'h00); send(8'hFF); send(8'h00); send(8'h00);
    chk("crc_zero", {pkt_done_o, crc_err_o}, 32'b10);
    hs_active_i = 1'b0; idle(2);
    chk("long_counts", {8'(n_hdr - b_hdr), 8'(n_done - b_done), 8'(n_plv - b_plv), 8'(n_last - b_last)},
        {8'd3, 8'd3, 8'd9, 8'd3});
    chk("long_no_trunc", n_trunc - b_trunc, 32'd0);

    // Burst ends after the 2nd payload byte of a wc=8 packet
    snap();
    hs_active_i = 1'b1; idle(1);
    send(8'hB8); send(8'h39); send(8'h08); send(8'h00); send(8'h2A);
    chk("trunc_hdr", {hdr_valid_o, ecc_err_o, hdr_wc_o}, {1'b1, 1'b0, 16'h0008});
    send(8'h11); send(8'h22);
    chk("trunc_pl1", {pl_valid_o, pl_data_o}, {1'b1, 8'h22});
    hs_active_i = 1'b0; byte_i = 8'h33; byte_valid_i = 1'b1;
    idle(1);
    byte_valid_i = 1'b0;
    chk("trunc_pulse", {trunc_err_o, pkt_done_o, pl_valid_o, pl_last_o}, 32'b1000);
    idle(2);
    chk("trunc_counts", {8'(n_trunc - b_trunc), 8'(n_done - b_done), 8'(n_plv - b_plv), 8'(n_last - b_last)},
        {8'd1, 8'd0, 8'd2, 8'd0});
    hs_active_i = 1'b1; idle(1);
    send(8'hB8); send(8'h05); send(8'h29); send(8'h00); send(8'h1C);
    chk("after_trunc", {hdr_valid_o, ecc_err_o, pkt_done_o, hdr_wc_o}, {1'b1, 1'b0, 1'b1, 16'h0029});
    hs_active_i = 1'b0; idle(2);

    // Same long packet with byte_valid gaps everywhere
    snap();
    hs_active_i = 1'b1; idle(1);
    send_gap(8'hB8); send_gap(8'h39); send_gap(8'h03); send_gap(8'h00); send_gap(8'h09);
    chk("stall_hdr", {hdr_valid_o, hdr_long_o, ecc_err_o, len_err_o, pkt_done_o, hdr_wc_o},
        {5'b11000, 16'h0003});
    send_gap(8'h2C);
    chk("stall_pl0", {pl_valid_o, pl_last_o, pl_data_o}, {1'b1, 1'b0, 8'h2C});
    send_gap(8'h00);
    chk("stall_pl1", {pl_valid_o, pl_last_o, pl_data_o}, {1'b1, 1'b0, 8'h00});
    send_gap(8'hFF);
    chk("stall_pl2", {pl_valid_o, pl_last_o, pl_data_o}, {1'b1, 1'b1, 8'hFF});
    send_gap(8'hD3); send_gap(8'h90);
    chk("stall_crc", {pkt_done_o, crc_err_o}, 32'b10);
    idle(2);
    chk("stall_counts", {8'(n_hdr - b_hdr), 8'(n_done - b_done), 8'(n_plv - b_plv), 8'(n_last - b_last)},
        {8'd1, 8'd1, 8'd3, 8'd1});
    hs_active_i = 1'b0; idle(2);

    // Oversized word count: header reported, payload dropped, resync on next burst
    snap();
    hs_active_i = 1'b1; idle(1);
    send(8'hB8); send(8'h39); send(8'h88); send(8'h13); send(8'h1A);
    chk("len_flags", {hdr_valid_o, len_err_o, ecc_err_o, hdr_long_o, pkt_done_o}, 32'b11010);
    chk("len_wc", hdr_wc_o, 32'h1388);
    send(8'h11); send(8'h22); send(8'h33);
    hs_active_i = 1'b0; idle(2);
    chk("len_counts", {8'(n_plv - b_plv), 8'(n_done - b_done), 8'(n_trunc - b_trunc)},
        {8'd0, 8'd0, 8'd0});
    hs_active_i = 1'b1; idle(1);
    send(8'hB8); send(8'h05); send(8'h11); send(8'h00); send(8'h36);
    chk("len_resync", {hdr_valid_o, ecc_err_o, len_err_o, pkt_done_o, hdr_wc_o},
        {4'b1001, 16'h0011});
    hs_active_i = 1'b0; idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsi_rx_packet_parser.md
Name: dsi_rx_packet_parser

Overview:
Receive-side counterpart to the DSI transmit path. It consumes the de-serialised byte stream of one HS data lane, after D-PHY LP->HS detection, hunts the SoT leader and splits each burst into DSI packets. For each packet it outputs header fields and a payload byte stream, and checks header ECC and payload CRC. It is used as a loopback checker for the transmit core and as the front end of a bridge-side receiver.

Parameters:
g_sync_byte, 8'hB8, SoT leader byte that opens every HS burst
g_check_zero_crc, 0, 1 = a received checksum of 16'h0000 is also checked; 0 = 16'h0000 means "not computed" and is accepted
g_max_wcount, 16'd4096, word counts above this abort the packet with len_err

Ports:
clk_i  in  1  byte clock (DSI byte-clock domain)
rst_i  in  1  synchronous reset, active-high
hs_active_i  in  1  high while the lane is in an HS burst
byte_i  in  8  received lane byte
byte_valid_i  in  1  byte_i qualifier
hdr_valid_o  out  1  1-cycle pulse; header fields valid
hdr_vc_o  out  2  virtual channel (DI[7:6])
hdr_dt_o  out  6  data type (DI[5:0])
hdr_wc_o  out  16  word count (long) / data0,data1 (short)
hdr_long_o  out  1  packet is long
pl_data_o  out  8  payload byte
pl_valid_o  out  1  payload byte qualifier
pl_last_o  out  1  final payload byte
pkt_done_o  out  1  1-cycle pulse at end of each packet
ecc_err_o  out  1  valid with hdr_valid_o; ECC mismatch
crc_err_o  out  1  valid with pkt_done_o; checksum mismatch
len_err_o  out  1  valid with hdr_valid_o; wc > g_max_wcount
trunc_err_o  out  1  1-cycle pulse; burst ended mid-packet

Behaviour:
- Reset: all outputs 0, FSM in IDLE, CRC register 16'hFFFF.
- States: IDLE, HUNT, HDR0..HDR3, PAYLOAD, CRC0, CRC1.
- IDLE -> HUNT when hs_active_i=1.
- HUNT: discard bytes until byte_i==g_sync_byte, then go to HDR0. Bytes before sync are not errors.
- HDR0..3 capture DI, WC lo, WC hi and ECC in that order. The state advances only on byte_valid_i.
- The ECC is the 6-bit DSI Hamming code over {WC hi, WC lo, DI}, bits [7:6] = 0. Detect only; no correction.
- Header output: hdr_valid_o is asserted in the cycle after the ECC byte is accepted, registered, with ecc_err_o and len_err_o.
- Next state after the header:
  - Short packet: pkt_done_o is pulsed in the same cycle as hdr_valid_o (crc_err_o=0); return to HDR0.
  - Long packet with wc==0: go to CRC0.
  - Long packet otherwise: go to PAYLOAD.
  - Long packet with ecc_err or len_err: hdr_valid_o still pulses, then return to HUNT. The payload is not emitted.
- PAYLOAD:
  - Each accepted byte appears on pl_data_o/pl_valid_o exactly 1 cycle later.
  - pl_last_o accompanies byte number wc.
  - The byte counter is 16 bits, decrementing; it never wraps.
- CRC: CRC-16, poly 0x1021 reflected (0x8408), init 0xFFFF, LSB-first, over payload bytes only.
- CRC0/CRC1 receive the checksum, LSB first. pkt_done_o pulses 1 cycle after the CRC1 byte, with crc_err_o = (rx != calc) && !(rx==0 && !g_check_zero_crc). Then return to HDR0.
- Back-to-back packets within a burst need no extra sync.
- hs_active_i falling:
  - In HUNT or HDR0 with no byte taken: go to IDLE silently.
  - Any other state: pulse trunc_err_o and go to IDLE. No pkt_done_o is issued, and pl_last_o is never issued for that packet.
  - Bytes with byte_valid_i in the falling cycle are ignored.
- rst_i mid-packet: immediate return to IDLE; no pulses are emitted.
- byte_valid_i low stalls every state; output pulses are never stretched.

Decomposition:
- Add to dsi_defs.vh:
  - the sync-byte constant
  - the long-packet data-type list (0x09,0x19,0x29,0x39,0x0C,0x1C,0x2C,0x3C,0x0D,0x0E,0x1E,0x2E,0x3E; all others short)
  - the 24-bit ECC function, shared with the transmit packet assembler
- One sub-module, dsi_rx_crc16: byte-wide CRC with init/enable/data inputs and a 16-bit remainder output.

Test Plan:
- Short packet: hs_active=1, bytes B8 05 11 00 36 -> hdr_valid with vc=0, dt=05, wc=0x0011, long=0, ecc_err=0; pkt_done with crc_err=0.
- Corrupted short: bytes B8 05 11 00 37 -> ecc_err=1 with hdr_valid; then B8-less packet 05 29 00 1C in the same burst parses cleanly.
- Long packet: DT 0x39, wc=3, payload 2C 00 FF, correct ECC/CRC from the model -> 3 pl_valid beats 1 cycle after input, pl_last on FF, pkt_done with crc_err=0. Flip one payload bit -> crc_err=1. Checksum 0000 with g_check_zero_crc=0 -> crc_err=0.
- Burst ends after the 2nd payload byte of a wc=8 packet -> trunc_err pulse, no pl_last, no pkt_done, FSM returns to IDLE, next burst parses normally.
- Stall: random byte_valid_i gaps during header, payload and CRC -> identical outputs to the gap-free run, single-cycle pulses only.
- Long header with wc=5000 and default g_max_wcount -> len_err=1, no payload emitted, parser resynchronises on the next burst.
